// File: rtl/keypad_pkg.sv
// Shared constants and the key-position-to-code mapping for the 4x3 keypad scanner.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 3;

    localparam logic [3:0] KEY_NONE = 4'h0;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_ZERO = 4'd11;
    localparam logic [3:0] KEY_HASH = 4'd12;

    // Phone layout: code = row*3 + col + 1, so * 0 # land on 10, 11, 12.
    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] row_w;
        logic [3:0] col_w;
        row_w = {2'b00, row};
        col_w = {2'b00, col};
        return row_w * 4'd3 + col_w + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row lines.
module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Reset to all-ones so an idle (pulled-up) keypad reads as "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= {WIDTH{1'b1}};
            sync_reg <= {WIDTH{1'b1}};
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
        end
    end

    assign synced = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x3 keypad reader with frame-based debounce; reports the
// lowest pressed key code once it has been stable for DEBOUNCE full frames.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEBOUNCE);

    logic [ROWS-1:0] rows_sync;

    logic [DW-1:0] dwell_reg, dwell_next;
    logic [1:0]    col_idx_reg, col_idx_next;
    logic [3:0]    frame_code_reg, frame_code_next;
    logic [3:0]    candidate_reg, candidate_next;
    logic [CW-1:0] stable_cnt_reg, stable_cnt_next;
    logic [3:0]    key_code_reg, key_code_next;
    logic          key_valid_reg, key_valid_next;
    logic          key_press_reg, key_press_next;

    logic [3:0]    row_code [ROWS];
    logic [3:0]    sample_code;
    logic [3:0]    merged_code;

    keypad_row_sync #(.WIDTH(ROWS)) u_row_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    (row_n),
        .synced (rows_sync)
    );

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_code[gi] = rows_sync[gi] ? KEY_NONE : key_code_of(2'(gi), col_idx_reg);
    end

    // Within one column the code grows with the row, so the lowest pressed row wins.
    always_comb begin
        sample_code = KEY_NONE;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_code[r] != KEY_NONE) sample_code = row_code[r];
        end
    end

    always_comb begin
        merged_code = frame_code_reg;
        if (sample_code != KEY_NONE &&
            (frame_code_reg == KEY_NONE || sample_code < frame_code_reg))
            merged_code = sample_code;
    end

    always_comb begin
        dwell_next      = dwell_reg + 1'b1;
        col_idx_next    = col_idx_reg;
        frame_code_next = frame_code_reg;
        candidate_next  = candidate_reg;
        stable_cnt_next = stable_cnt_reg;
        key_code_next   = key_code_reg;
        key_press_next  = 1'b0;

        if (dwell_reg == DWELL_LAST) begin
            dwell_next = '0;
            if (col_idx_reg == 2'(COLS - 1)) begin
                col_idx_next    = 2'd0;
                frame_code_next = KEY_NONE;
                if (merged_code == candidate_reg) begin
                    if (stable_cnt_reg != CNT_FULL) stable_cnt_next = stable_cnt_reg + 1'b1;
                end else begin
                    candidate_next  = merged_code;
                    stable_cnt_next = CW'(1);
                end
                if (stable_cnt_next == CNT_FULL && candidate_next != key_code_reg) begin
                    key_code_next  = candidate_next;
                    key_press_next = (candidate_next != KEY_NONE);
                end
            end else begin
                col_idx_next    = col_idx_reg + 2'd1;
                frame_code_next = merged_code;
            end
        end

        key_valid_next = (key_code_next != KEY_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg      <= '0;
            col_idx_reg    <= 2'd0;
            frame_code_reg <= KEY_NONE;
            candidate_reg  <= KEY_NONE;
            stable_cnt_reg <= '0;
            key_code_reg   <= KEY_NONE;
            key_valid_reg  <= 1'b0;
            key_press_reg  <= 1'b0;
        end else begin
            dwell_reg      <= dwell_next;
            col_idx_reg    <= col_idx_next;
            frame_code_reg <= frame_code_next;
            candidate_reg  <= candidate_next;
            stable_cnt_reg <= stable_cnt_next;
            key_code_reg   <= key_code_next;
            key_valid_reg  <= key_valid_next;
            key_press_reg  <= key_press_next;
        end
    end

    assign col_n     = ~(3'b001 << col_idx_reg);
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_press = key_press_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix drives row_n
// from col_n, with vector tables plus hand-written multi-cycle sequences.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;

    logic [11:0] keys = '0;      // bit index = row*3 + col
    logic        force_low = 1'b0;
    int          press_count = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [11:0] keys;
        logic [3:0]  code;
        int          presses;
    } vec_t;

    vec_t vecs [10];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_press (key_press)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
        if (force_low) row_n = 4'h0;
    end

    always @(negedge clk) if (key_press === 1'b1) press_count++;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Returns just after the edge on which column 0 becomes driven again.
    task automatic align_frame();
        logic [2:0] last;
        int found;
        last  = col_n;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (col_n == 3'b110 && last == 3'b011) found = 1;
            last = col_n;
        end
        check("frame_align", found, 1);
    endtask

    task automatic settle(input logic [11:0] k);
        align_frame();
        keys = k;
        repeat (39) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] col_seq [3];
        int p0;
        int bad;
        int found;

        col_seq[0] = 3'b110;
        col_seq[1] = 3'b101;
        col_seq[2] = 3'b011;

        vecs[0] = '{12'h010, 4'd5,  1};
        vecs[1] = '{12'h000, 4'd0,  0};
        vecs[2] = '{12'h044, 4'd3,  1};
        vecs[3] = '{12'h040, 4'd7,  1};
        vecs[4] = '{12'h000, 4'd0,  0};
        vecs[5] = '{12'h001, 4'd1,  1};
        vecs[6] = '{12'h801, 4'd1,  0};
        vecs[7] = '{12'h800, 4'd12, 1};
        vecs[8] = '{12'h200, 4'd10, 1};
        vecs[9] = '{12'h000, 4'd0,  0};

        // Reset with rows forced low
        force_low = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_col_n", col_n, 3'b110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_press", key_press, 0);
        @(negedge clk);
        rst = 1'b0;
        force_low = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check("scan_col_n", col_n, col_seq[(i / 4) % 3]);
            @(posedge clk);
            #1;
        end
        $display("reset: col_n scan sequence observed, key_code=%0d", key_code);

        for (int v = 0; v < 10; v++) begin
            align_frame();
            keys = vecs[v].keys;
            p0 = press_count;
            repeat (39) @(posedge clk);
            #1;
            check("vec_key_code", key_code, vecs[v].code);
            check("vec_key_valid", key_valid, (vecs[v].code != 0) ? 1 : 0);
            check("vec_presses", press_count - p0, vecs[v].presses);
            $display("vec %0d keys=%03h key_code=%0d valid=%0d presses=%0d",
                     v, vecs[v].keys, key_code, key_valid, press_count - p0);
        end

        // Bounce: '#' alternates every frame, never three equal frames
        align_frame();
        bad = 0;
        p0 = press_count;
        for (int f = 0; f < 7; f++) begin
            keys = (f % 2 == 0) ? 12'h800 : 12'h000;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (key_code != 4'd0 || key_press !== 1'b0) bad++;
            end
        end
        check("bounce_hold_zero", bad, 0);
        check("bounce_no_press", press_count - p0, 0);
        keys = 12'h800;
        repeat (39) @(posedge clk);
        #1;
        check("bounce_then_steady", key_code, 12);
        check("bounce_steady_press", press_count - p0, 1);
        $display("bounce: key_code=%0d presses=%0d", key_code, press_count - p0);

        // Held '0' for 500 cycles
        settle(12'h000);
        check("held_release", key_code, 0);
        p0 = press_count;
        settle(12'h400);
        check("held_code", key_code, 11);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (key_code != 4'd11) bad++;
        end
        check("held_stable", bad, 0);
        check("held_presses", press_count - p0, 1);
        $display("held: key_code=%0d presses=%0d", key_code, press_count - p0);

        // Reset while '9' is held
        settle(12'h000);
        settle(12'h100);
        check("mid_hold_code", key_code, 9);
        p0 = press_count;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_key_code", key_code, 0);
        check("mid_rst_key_valid", key_valid, 0);
        check("mid_rst_col_n", col_n, 3'b110);
        @(negedge clk);
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (key_code == 4'd9) found = 1;
        end
        check("rereport_found", found, 1);
        @(posedge clk);
        #1;
        check("rereport_press", press_count - p0, 1);
        check("rereport_valid", key_valid, 1);
        $display("reset-hold: key_code=%0d presses=%0d", key_code, press_count - p0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
